// File: rtl/osc_spi_pkg.sv
// Shared definitions for the DAC command-frame SPI link: frame geometry,
// command codes and the receiver state encoding.
package osc_spi_pkg;

  localparam int unsigned DEF_FRAME_BITS  = 24;
  localparam int unsigned DEF_CMD_BITS    = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned CNT_W           = 5;

  localparam logic [7:0] SEND_CHANNEL_A = 8'b00110001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_e;

endpackage

// File: rtl/spi_frame_rx_if.sv
// Holding-register bus between the SPI frame receiver (master) and its consumer.
interface spi_frame_rx_if
  import osc_spi_pkg::*;
#(
  parameter int unsigned CMD_W  = DEF_CMD_BITS,
  parameter int unsigned DATA_W = DEF_FRAME_BITS - DEF_CMD_BITS
);

  logic [CMD_W-1:0]  cmd_out;
  logic [DATA_W-1:0] data_out;
  logic              frame_valid;
  logic              frame_ack;
  logic              frame_error;
  logic              overrun;

  modport master (
    output cmd_out, data_out, frame_valid, frame_error, overrun,
    input  frame_ack
  );

  modport slave (
    input  cmd_out, data_out, frame_valid, frame_error, overrun,
    output frame_ack
  );

endinterface

// File: rtl/spi_input_sync.sv
// Synchronizer for one asynchronous SPI pin plus a history register that
// yields the synchronized level and single-cycle rise/fall strobes.
module spi_input_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock_in,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_c  = sync_q[STAGES-1] & ~prev_q;
  assign fall_c  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave receiver for command+data frames: oversampled pins, bit-count
// validation and a single-entry valid/ack holding register.
module spi_frame_rx
  import osc_spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = DEF_FRAME_BITS,
  parameter int unsigned CMD_BITS    = DEF_CMD_BITS,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic                spi_cs_in,
  input  logic                spi_clock_in,
  input  logic                spi_data_in,
  spi_frame_rx_if.master      bus
);

  localparam int unsigned DATA_BITS = FRAME_BITS - CMD_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(FRAME_BITS);

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic data_level, data_rise, data_fall;
  logic unused_edges_c;

  spi_input_sync #(.STAGES(SYNC_STAGES)) u_cs (
    .clock_in(clock_in), .reset(reset), .pin_i(spi_cs_in),
    .level_o(cs_level), .rise_c(cs_rise), .fall_c(cs_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES)) u_sclk (
    .clock_in(clock_in), .reset(reset), .pin_i(spi_clock_in),
    .level_o(sclk_level), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES)) u_data (
    .clock_in(clock_in), .reset(reset), .pin_i(spi_data_in),
    .level_o(data_level), .rise_c(data_rise), .fall_c(data_fall)
  );

  assign unused_edges_c = ^{cs_level, sclk_level, sclk_fall, data_rise, data_fall};

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CMD_BITS-1:0]   cmd_q, cmd_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic                  overrun_q, overrun_d;
  logic                  slot_free;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  // An ack in the completion cycle frees the slot for the arriving frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    valid_d   = valid_q & ~bus.frame_ack;
    error_d   = 1'b0;
    overrun_d = 1'b0;
    slot_free = ~valid_q | bus.frame_ack;

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        shift_d = '0;
        if (cs_fall) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], data_level};
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        if (cs_rise) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (cnt_q != CNT_GOOD) begin
          error_d = 1'b1;
        end else if (slot_free) begin
          cmd_d   = shift_q[FRAME_BITS-1 -: CMD_BITS];
          data_d  = shift_q[DATA_BITS-1:0];
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cmd_out     = cmd_q;
  assign bus.data_out    = data_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_error = error_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: a frame-level model predicts each
// frame's outcome and the holding register, checked every cycle.
module tb_spi_frame_rx;
  import osc_spi_pkg::*;

  localparam int FB     = 24;
  localparam int SYNC   = 2;
  localparam int LAT_LO = SYNC + 2;
  localparam int LAT_HI = SYNC + 4;
  localparam int P_NONE = 0;
  localparam int P_GOOD = 1;
  localparam int P_BAD  = 2;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic spi_cs   = 1'b1;
  logic spi_sclk = 1'b0;
  logic spi_data = 1'b0;

  spi_frame_rx_if #(.CMD_W(8), .DATA_W(16)) bus ();

  spi_frame_rx #(.FRAME_BITS(FB), .CMD_BITS(8), .SYNC_STAGES(SYNC)) dut (
    .clock_in(clk), .reset(reset), .spi_cs_in(spi_cs),
    .spi_clock_in(spi_sclk), .spi_data_in(spi_data), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // frame-level model state
  logic        model_valid = 1'b0;
  logic [7:0]  model_cmd   = 8'h00;
  logic [15:0] model_data  = 16'h0000;
  int          pend_kind   = P_NONE;
  int          pend_c      = 0;
  logic [7:0]  pend_cmd    = 8'h00;
  logic [15:0] pend_data   = 16'h0000;
  int          meas_lat    = LAT_LO;
  int          err_seen    = 0;
  int          ovr_seen    = 0;
  int          load_seen   = 0;
  logic        valid_low_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    int d;
    if (!reset) begin
      d = cyc - pend_c;
      if (bus.frame_error) begin
        err_seen++;
        n_checks++;
        if (pend_kind == P_BAD && d >= LAT_LO && d <= LAT_HI) pend_kind = P_NONE;
        else begin
          n_fail++;
          $display("FAIL frame_error: pulse at %0d cycles after cs rise, pending kind %0d, expected none", d, pend_kind);
        end
      end
      if (bus.overrun) begin
        ovr_seen++;
        n_checks++;
        if (pend_kind == P_GOOD && model_valid && d >= LAT_LO && d <= LAT_HI) pend_kind = P_NONE;
        else begin
          n_fail++;
          $display("FAIL overrun: pulse at %0d cycles after cs rise, pending kind %0d, model valid %0b, expected none", d, pend_kind, model_valid);
        end
      end
      if (pend_kind == P_GOOD && !model_valid && bus.frame_valid) begin
        load_seen++;
        n_checks++;
        if (d < LAT_LO || d > LAT_HI || bus.cmd_out != pend_cmd || bus.data_out != pend_data) begin
          n_fail++;
          $display("FAIL load: got %h_%h at latency %0d, expected %h_%h within %0d..%0d",
                   bus.cmd_out, bus.data_out, d, pend_cmd, pend_data, LAT_LO, LAT_HI);
        end
        model_valid = 1'b1;
        model_cmd   = pend_cmd;
        model_data  = pend_data;
        meas_lat    = d;
        pend_kind   = P_NONE;
      end
      if (pend_kind != P_NONE && d > LAT_HI) begin
        n_checks++;
        n_fail++;
        $display("FAIL outcome timeout: kind %0d not observed within %0d cycles of cs rise", pend_kind, LAT_HI);
        pend_kind = P_NONE;
      end
      if (!bus.frame_valid) valid_low_seen = 1'b1;
      if (!(pend_kind == P_GOOD && !model_valid)) begin
        n_checks++;
        if (bus.frame_valid !== model_valid || bus.cmd_out !== model_cmd || bus.data_out !== model_data) begin
          n_fail++;
          $display("FAIL hold: got v=%0b %h_%h, expected v=%0b %h_%h at cycle %0d",
                   bus.frame_valid, bus.cmd_out, bus.data_out, model_valid, model_cmd, model_data, cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int half);
    spi_data = b;
    repeat (half) @(negedge clk);
    spi_sclk = 1'b1;
    repeat (half) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  // One CS-framed burst of nbits; 24-bit frames carry val, others random bits.
  task automatic send_frame(input int nbits, input logic [23:0] val, input int half, input bit ack_sync);
    int c0;
    logic b;
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (half + 1) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b = (nbits == FB) ? val[FB-1-i] : 1'($urandom_range(0, 1));
      send_bit(b, half);
    end
    spi_cs    = 1'b1;
    c0        = cyc;
    pend_c    = c0;
    pend_cmd  = val[23:16];
    pend_data = val[15:0];
    pend_kind = (nbits == FB) ? P_GOOD : P_BAD;
    if (ack_sync) begin
      while (cyc < c0 + meas_lat - 1) @(negedge clk);
      bus.frame_ack = 1'b1;
      @(posedge clk);
      #1;
      model_valid   = 1'b0;
      bus.frame_ack = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.frame_ack = 1'b1;
    @(posedge clk);
    #1;
    model_valid   = 1'b0;
    bus.frame_ack = 1'b0;
  endtask

  initial begin
    int e0, o0, l0, nb, r;
    bus.frame_ack = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset valid", 32'(bus.frame_valid), 32'h0);
    chk("reset cmd", 32'(bus.cmd_out), 32'h0);
    chk("reset data", 32'(bus.data_out), 32'h0);
    chk("reset pulses", 32'({bus.frame_error, bus.overrun}), 32'h0);

    // basic frame at SCLK = clk/8
    send_frame(FB, {SEND_CHANNEL_A, 16'hABCD}, 4, 1'b0);
    chk("basic cmd", 32'(bus.cmd_out), 32'h31);
    chk("basic data", 32'(bus.data_out), 32'hABCD);
    chk("basic valid", 32'(bus.frame_valid), 32'h1);
    chk("basic latency in window", 32'(meas_lat >= LAT_LO && meas_lat <= LAT_HI), 32'h1);
    do_ack();
    @(negedge clk);
    chk("ack clears valid", 32'(bus.frame_valid), 32'h0);

    // short and long frames
    e0 = err_seen;
    send_frame(23, 24'h0, 4, 1'b0);
    send_frame(25, 24'h0, 4, 1'b0);
    chk("length errors", 32'(err_seen - e0), 32'd2);
    chk("errors keep data", 32'(bus.data_out), 32'hABCD);
    chk("errors keep valid low", 32'(bus.frame_valid), 32'h0);

    // overrun
    o0 = ovr_seen;
    send_frame(FB, {SEND_CHANNEL_A, 16'h0001}, 4, 1'b0);
    send_frame(FB, {SEND_CHANNEL_A, 16'h0002}, 4, 1'b0);
    chk("overrun count", 32'(ovr_seen - o0), 32'd1);
    chk("overrun keeps data", 32'(bus.data_out), 32'h0001);
    do_ack();
    send_frame(FB, {SEND_CHANNEL_A, 16'h0003}, 4, 1'b0);
    chk("after overrun data", 32'(bus.data_out), 32'h0003);

    // ack coinciding with completion
    o0 = ovr_seen;
    valid_low_seen = 1'b0;
    send_frame(FB, {SEND_CHANNEL_A, 16'h1234}, 4, 1'b1);
    chk("sim ack no overrun", 32'(ovr_seen - o0), 32'd0);
    chk("sim ack data", 32'(bus.data_out), 32'h1234);
    chk("sim ack valid stays high", 32'(valid_low_seen), 32'h0);

    // reset mid-frame
    e0 = err_seen;
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)), 4);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_valid = 1'b0;
    model_cmd   = 8'h00;
    model_data  = 16'h0000;
    pend_kind   = P_NONE;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)), 4);
    spi_cs = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort no error", 32'(err_seen - e0), 32'd0);
    chk("abort no valid", 32'(bus.frame_valid), 32'h0);
    chk("abort cleared data", 32'(bus.data_out), 32'h0);
    send_frame(FB, {SEND_CHANNEL_A, 16'h5555}, 4, 1'b0);
    chk("post reset cmd", 32'(bus.cmd_out), 32'h31);
    chk("post reset data", 32'(bus.data_out), 32'h5555);
    do_ack();

    // randomized frames, lengths and acks
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) nb = FB;
      else if (r == 6) nb = 23;
      else if (r == 7) nb = 25;
      else nb = int'($urandom_range(0, 34));
      send_frame(nb, 24'($urandom), int'($urandom_range(2, 4)), 1'b0);
      if ($urandom_range(0, 1) == 1) do_ack();
    end
    do_ack();

    // loopback sweep at SCLK = clk/4
    e0 = err_seen;
    l0 = load_seen;
    for (int k = 0; k < 256; k++) begin
      send_frame(FB, {SEND_CHANNEL_A, 16'(k * 257)}, 2, 1'b0);
      do_ack();
    end
    chk("sweep errors", 32'(err_seen - e0), 32'd0);
    chk("sweep loads", 32'(load_seen - l0), 32'd256);
    chk("sweep last data", 32'(bus.data_out), 32'hFFFF);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
